// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if -- handshake and HI/LO bus between the multi-cycle
// controller / register file and the multiply-divide unit.
//   start, op, a, b       : operation request (op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   hi_we, lo_we, wdata   : MTHI / MTLO writes
//   busy, done            : status (registered in the unit)
//   hi, lo                : architectural HI / LO registers
// Modports: master = controller side, slave = the unit.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit -- iterative 32-bit MULT/MULTU/DIV/DIVU unit owning HI/LO.
// One operation takes 32 RUN cycles (one shift-add or restoring step per
// cycle) plus one FIX cycle that applies sign correction and writes HI/LO.
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset (aborts any operation, clears HI/LO)
//   bus      mult_div_unit_if.slave: start/op/a/b request, MTHI/MTLO writes,
//            registered busy/done, HI/LO outputs
// Build option: define MDU_DIV_EN to compile in the divider. Without it,
// divide ops go straight to FIX, leave HI/LO untouched and still pulse done.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input logic             clk,
    input logic             rst,
    mult_div_unit_if.slave  bus
);
    localparam int W = WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t         state;
    logic           is_div;
    logic           sa;        // sign of a (signed ops only)
    logic           sb;        // sign of b (signed ops only)
    logic [W-1:0]   opa;       // |a|: multiplicand, or dividend shifted out MSB-first
    logic [W-1:0]   opb;       // |b|: multiplier shifted out LSB-first, or divisor
    logic [2*W-1:0] acc;       // product, or {remainder, quotient}
    logic [5:0]     cnt;
    logic           busy_q;
    logic           done_q;
    logic [W-1:0]   hi_q;
    logic [W-1:0]   lo_q;

    // Operand conditioning at start. |0x80000000| stays 0x80000000,
    // which is the right unsigned magnitude.
    logic           a_neg;
    logic           b_neg;
    logic [W-1:0]   abs_a;
    logic [W-1:0]   abs_b;

    always_comb begin
        a_neg = ~bus.op[0] & bus.a[W-1];
        b_neg = ~bus.op[0] & bus.b[W-1];
        abs_a = a_neg ? -bus.a : bus.a;
        abs_b = b_neg ? -bus.b : bus.b;
    end

    // Shift-add step: add the multiplicand into the upper half when the
    // current multiplier bit is set, then shift the whole accumulator right
    // keeping the carry.
    logic [W:0]     madd;
    logic [2*W-1:0] mul_next;
    logic [2*W-1:0] prod;

    always_comb begin
        madd     = {1'b0, acc[2*W-1:W]} + (opb[0] ? {1'b0, opa} : {(W+1){1'b0}});
        mul_next = {madd, acc[W-1:1]};
        prod     = (sa ^ sb) ? -acc : acc;
    end

`ifdef MDU_DIV_EN
    // Restoring step: shift the next dividend bit into the partial
    // remainder, trial-subtract the divisor, keep the difference only when
    // it did not borrow. Quotient bits enter acc from the bottom.
    logic [W-1:0]   a_raw;
    logic [W:0]     rsh;
    logic [W+1:0]   diff;
    logic [2*W-1:0] div_next;
    logic [W-1:0]   div_hi;
    logic [W-1:0]   div_lo;

    always_comb begin
        rsh  = {acc[2*W-1:W], opa[W-1]};
        diff = {1'b0, rsh} - {2'b00, opb};
        if (diff[W+1])
            div_next = {rsh[W-1:0], acc[W-2:0], 1'b0};
        else
            div_next = {diff[W-1:0], acc[W-2:0], 1'b1};

        // Divide by zero returns the raw dividend and all-ones quotient
        // with no sign fix. Otherwise the quotient sign is the XOR of the
        // operand signs and the remainder follows the dividend; the
        // 0x80000000 / -1 overflow falls out of the two's complement wrap.
        if (opb == '0) begin
            div_hi = a_raw;
            div_lo = '1;
        end else begin
            div_hi = sa ? -acc[2*W-1:W] : acc[2*W-1:W];
            div_lo = (sa ^ sb) ? -acc[W-1:0] : acc[W-1:0];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            is_div <= 1'b0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            opa    <= '0;
            opb    <= '0;
            acc    <= '0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
`ifdef MDU_DIV_EN
            a_raw  <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    // MTHI/MTLO only land while idle; a same-cycle start is
                    // still accepted and FIX overwrites later.
                    if (bus.hi_we) hi_q <= bus.wdata;
                    if (bus.lo_we) lo_q <= bus.wdata;
                    if (bus.start) begin
                        is_div <= bus.op[1];
                        sa     <= a_neg;
                        sb     <= b_neg;
                        opa    <= abs_a;
                        opb    <= abs_b;
                        acc    <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
`ifdef MDU_DIV_EN
                        a_raw  <= bus.a;
                        state  <= RUN;
`else
                        // No divider: let divide ops complete immediately so
                        // the controller's stall still releases.
                        state  <= bus.op[1] ? FIX : RUN;
`endif
                    end
                end

                RUN: begin
`ifdef MDU_DIV_EN
                    if (is_div) begin
                        acc <= div_next;
                        opa <= opa << 1;
                    end else
`endif
                    begin
                        acc <= mul_next;
                        opb <= opb >> 1;
                    end
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31) state <= FIX;
                end

                FIX: begin
                    if (!is_div) begin
                        hi_q <= prod[2*W-1:W];
                        lo_q <= prod[W-1:0];
                    end
`ifdef MDU_DIV_EN
                    else begin
                        hi_q <= div_hi;
                        lo_q <= div_lo;
                    end
`endif
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit -- scoreboard bench for mult_div_unit. Expected HI/LO are
// computed by a behavioural model when an op is issued, queued, and popped
// when done is seen. Latency and busy length are checked per op. Divide
// expectations follow the MDU_DIV_EN setting of the build.
module tb_mult_div_unit;
`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    logic [31:0] mdl_hi;
    logic [31:0] mdl_lo;
    logic [63:0] sb_q[$];

    mult_div_unit_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] chi,
                                          input logic [31:0] clo);
        logic [63:0] xa;
        logic [63:0] xb;
        longint      sx;
        longint      sy;
        longint      q;
        longint      r;
        logic [63:0] qv;
        logic [63:0] rv;
        if (op == 2'b00) begin
            xa = {{32{a[31]}}, a};
            xb = {{32{b[31]}}, b};
            return xa * xb;
        end
        if (op == 2'b01) begin
            xa = {32'h0, a};
            xb = {32'h0, b};
            return xa * xb;
        end
        if (!DIV_EN) return {chi, clo};
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (op == 2'b11) return {a % b, a / b};
        sx = $signed(a);
        sy = $signed(b);
        q  = sx / sy;
        r  = sx % sy;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
    endfunction

    // Issues one op and waits for done. poke>0 pulses start+hi_we during RUN
    // at that cycle; wr_hi writes wd to HI alongside the start.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int poke, input logic wr_hi, input logic [31:0] wd,
                          input string tag);
        int          n;
        int          nbusy;
        int          lat;
        logic [63:0] exp;
        logic [63:0] got;
        if (wr_hi) mdl_hi = wd;
        sb_q.push_back(model(op, a, b, mdl_hi, mdl_lo));
        lat = (op[1] && !DIV_EN) ? 2 : 34;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.hi_we = wr_hi;
        bus.wdata = wd;
        n = 0;
        nbusy = 0;
        do begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.hi_we = 1'b0;
            n++;
            if (bus.busy) nbusy++;
            if (n == 1 && wr_hi) begin
                vectors++;
                if (bus.hi !== wd) begin
                    miscompares++;
                    $display("FAIL %s mthi_with_start: hi=%h expected %h", tag, bus.hi, wd);
                end
            end
            if (poke > 0 && n == poke) begin
                bus.start = 1'b1;
                bus.op    = 2'b11;
                bus.b     = 32'h0;
                bus.hi_we = 1'b1;
                bus.wdata = 32'h0000_AAAA;
            end
        end while (!bus.done && n < 100);
        vectors++;
        if (n !== lat) begin
            miscompares++;
            $display("FAIL %s latency: got %0d edges expected %0d", tag, n, lat);
        end
        vectors++;
        if (nbusy !== lat - 1) begin
            miscompares++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", tag, nbusy, lat - 1);
        end
        exp = sb_q.pop_front();
        got = {bus.hi, bus.lo};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s hi_lo: got %h expected %h", tag, got, exp);
        end
        mdl_hi = exp[63:32];
        mdl_lo = exp[31:0];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mdl_hi = '0;
        mdl_lo = '0;
        vectors++;
        if ({bus.busy, bus.done, bus.hi, bus.lo} !== 66'h0) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h expected all 0",
                     bus.busy, bus.done, bus.hi, bus.lo);
        end
    endtask

    task automatic test_mult();
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, 32'h0, "multu_max");
        @(negedge clk);
        vectors++;
        if (bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL done_one_cycle: done=%b expected 0", bus.done);
        end
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0, 1'b0, 32'h0, "mult_neg3x7");
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0, 1'b0, 32'h0, "mult_minmin");
        for (int i = 0; i < 4; i++) begin
            run_op(2'(i % 2), $urandom, $urandom, 0, 1'b0, 32'h0, "mult_rand");
        end
    endtask

    task automatic test_div();
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, 32'h0, "div_neg7_2");
        run_op(2'b11, 32'd100, 32'd7, 0, 1'b0, 32'h0, "divu_100_7");
        run_op(2'b11, 32'h0000_1234, 32'h0, 0, 1'b0, 32'h0, "divu_by_zero");
        run_op(2'b10, 32'hFFFF_FFF0, 32'h0, 0, 1'b0, 32'h0, "div_by_zero");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, 32'h0, "div_overflow");
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 0, 1'b0, 32'h0, "div_7_neg2");
        run_op(2'b11, 32'hFFFF_FFFF, 32'd1, 0, 1'b0, 32'h0, "divu_max_1");
        for (int i = 0; i < 4; i++) begin
            run_op(2'b10 + 2'(i % 2), $urandom, $urandom_range(1, 70000), 0, 1'b0, 32'h0,
                   "div_rand");
        end
    endtask

    task automatic test_ignore_when_busy();
        run_op(2'b01, 32'h0001_0003, 32'h0002_0005, 5, 1'b0, 32'h0, "multu_poked");
        bus.lo_we = 1'b1;
        bus.wdata = 32'h0000_0055;
        @(negedge clk);
        bus.lo_we = 1'b0;
        mdl_lo = 32'h0000_0055;
        vectors++;
        if ({bus.hi, bus.lo} !== {mdl_hi, mdl_lo}) begin
            miscompares++;
            $display("FAIL mtlo_after_done: got %h expected %h", {bus.hi, bus.lo}, {mdl_hi, mdl_lo});
        end
        bus.hi_we = 1'b1;
        bus.wdata = 32'h1111_2222;
        @(negedge clk);
        bus.hi_we = 1'b0;
        mdl_hi = 32'h1111_2222;
        vectors++;
        if ({bus.hi, bus.lo} !== {mdl_hi, mdl_lo}) begin
            miscompares++;
            $display("FAIL mthi_idle: got %h expected %h", {bus.hi, bus.lo}, {mdl_hi, mdl_lo});
        end
        run_op(2'b00, 32'd12, 32'hFFFF_FFFB, 0, 1'b1, 32'hDEAD_BEEF, "mult_with_mthi");
        run_op(2'b10, 32'd50, 32'd6, 0, 1'b1, 32'h0BAD_F00D, "div_with_mthi");
    endtask

    task automatic test_reset_abort();
        int ndone;
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.a     = 32'h0000_0123;
        bus.b     = 32'h0000_0456;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mdl_hi = '0;
        mdl_lo = '0;
        vectors++;
        if ({bus.busy, bus.done, bus.hi, bus.lo} !== 66'h0) begin
            miscompares++;
            $display("FAIL reset_abort: busy=%b done=%b hi=%h lo=%h expected all 0",
                     bus.busy, bus.done, bus.hi, bus.lo);
        end
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) ndone++;
        end
        vectors++;
        if (ndone !== 0) begin
            miscompares++;
            $display("FAIL reset_no_done: got %0d busy/done cycles expected 0", ndone);
        end
        run_op(2'b00, 32'h0000_0123, 32'hFFFF_FC00, 0, 1'b0, 32'h0, "mult_after_reset");
    endtask

    task automatic test_back_to_back();
        run_op(2'b01, 32'h89AB_CDEF, 32'h0000_0010, 0, 1'b0, 32'h0, "b2b_first");
        run_op(2'b11, 32'hCAFE_0000, 32'h0000_1000, 0, 1'b0, 32'h0, "b2b_second");
        run_op(2'b00, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 1'b0, 32'h0, "b2b_third");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.a       = '0;
        bus.b       = '0;
        bus.hi_we   = 1'b0;
        bus.lo_we   = 1'b0;
        bus.wdata   = '0;
        test_reset();
        test_mult();
        test_div();
        test_ignore_when_busy();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
